// File: rtl/pl_reg_flow_ctrl_if.sv
// rtl/pl_reg_flow_ctrl_if.sv - valid/ready handshake and rank-enable bundle of the pipeline flow controller
interface pl_reg_flow_ctrl_if #(
    parameter int R  = 3,
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [R-1:0]  enable;
    logic [CW-1:0] occupancy;
    logic          busy;

    // Controller side: consumes producer/consumer strobes, drives ready/valid and rank enables
    modport master (
        input  in_valid, out_ready, flush,
        output in_ready, out_valid, enable, occupancy, busy
    );

    // Environment side: producer, consumer and flush source
    modport slave (
        output in_valid, out_ready, flush,
        input  in_ready, out_valid, enable, occupancy, busy
    );
endinterface

// File: rtl/pl_reg_flow_ctrl.sv
// rtl/pl_reg_flow_ctrl.sv - valid/ready flow controller driving per-rank load enables of a pipeline register
module pl_reg_flow_ctrl #(
    parameter int stages     = 4,
    parameter int stall_mode = 1,
    parameter int cnt_width  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    pl_reg_flow_ctrl_if.master  bus
);
    localparam int R = stages - 1;

    // Reject pipe depths with no rank or an occupancy counter too narrow to hold R
    generate
        if (stages < 2 || (2 ** cnt_width) <= R) begin : g_bad_params
            $error("pl_reg_flow_ctrl: illegal stages/cnt_width combination");
        end
    endgenerate

    logic [R-1:0]         v_q;
    logic [R-1:0]         v_d;
    logic [R-1:0]         en;
    logic [cnt_width-1:0] occ;

    // Rank enables: a rank may load when it is empty or its successor moves on.
    // Global mode only looks at the output rank, so bubbles ride along with the stall.
    always_comb begin
        en = '0;
        if (stall_mode == 0) begin
            en = {R{!v_q[R-1] | bus.out_ready}};
        end else begin
            en[R-1] = !v_q[R-1] | bus.out_ready;
            for (int i = R - 2; i >= 0; i--) begin
                en[i] = !v_q[i] | en[i+1];
            end
        end
        if (bus.flush) begin
            en = '0;
        end
    end

    // Next valid vector: enabled ranks take their predecessor's validity, flush empties the pipe
    always_comb begin
        v_d = v_q;
        if (bus.flush) begin
            v_d = '0;
        end else begin
            if (en[0]) begin
                v_d[0] = bus.in_valid;
            end
            for (int i = 1; i < R; i++) begin
                if (en[i]) begin
                    v_d[i] = v_q[i-1];
                end
            end
        end
    end

    // Valid-vector register; reset empties the pipe without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // Occupancy is the population count of the valid vector
    always_comb begin
        occ = '0;
        for (int i = 0; i < R; i++) begin
            occ = occ + cnt_width'(v_q[i]);
        end
    end

    assign bus.enable    = en;
    assign bus.in_ready  = en[0];
    assign bus.out_valid = v_q[R-1];
    assign bus.occupancy = occ;
    assign bus.busy      = |v_q;
endmodule

// File: tb/tb_pl_reg_flow_ctrl.sv
// tb/tb_pl_reg_flow_ctrl.sv - directed self-checking bench for pl_reg_flow_ctrl in both stall modes
module tb_pl_reg_flow_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic flush;
    int   n_vec = 0;
    int   n_err = 0;

    pl_reg_flow_ctrl_if #(.R(3), .CW(3)) b1 ();
    pl_reg_flow_ctrl_if #(.R(3), .CW(3)) b0 ();

    assign b1.in_valid  = in_valid;
    assign b1.out_ready = out_ready;
    assign b1.flush     = flush;
    assign b0.in_valid  = in_valid;
    assign b0.out_ready = out_ready;
    assign b0.flush     = flush;

    pl_reg_flow_ctrl #(.stages(4), .stall_mode(1), .cnt_width(3)) u_m1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pl_reg_flow_ctrl #(.stages(4), .stall_mode(0), .cnt_width(3)) u_m0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input string tag);
        int ov[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
        int oc[9] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
        int n_out = 0;
        int n_in  = 0;
        for (int c = 0; c < 9; c++) begin
            in_valid  = (c < 5);
            out_ready = 1'b1;
            flush     = 1'b0;
            #1;
            check({tag, ".out_valid"}, b1.out_valid, ov[c]);
            check({tag, ".occ"},       b1.occupancy, oc[c]);
            check({tag, ".busy"},      b1.busy,      (oc[c] != 0));
            check({tag, ".in_ready"},  b1.in_ready,  1);
            check({tag, ".m0_occ"},    b0.occupancy, oc[c]);
            if (b1.out_valid && out_ready) n_out++;
            if (in_valid && b1.in_ready) n_in++;
            tick;
        end
        check({tag, ".n_in"},  n_in,  5);
        check({tag, ".n_out"}, n_out, 5);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int iv[6]    = '{1, 0, 1, 0, 0, 0};
        int m0_ir[6] = '{1, 1, 1, 0, 0, 0};
        int bo_oc[6] = '{0, 1, 1, 2, 2, 2};
        int m0_ov[4] = '{1, 0, 1, 0};
        int m1_ov[4] = '{1, 1, 0, 0};
        int bp_ir[4] = '{1, 1, 1, 0};
        int bp_oc[4] = '{0, 1, 2, 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state, held and after release
        tick;
        tick;
        check("rst_hold.enable",   b1.enable,   3'b111);
        check("rst_hold.in_ready", b1.in_ready, 1);
        check("rst_hold.busy",     b1.busy,     0);
        rst_n = 1'b1;
        #1;
        check("rst.out_valid", b1.out_valid, 0);
        check("rst.occ",       b1.occupancy, 0);
        check("rst.busy",      b1.busy,      0);
        check("rst.in_ready",  b1.in_ready,  1);
        check("rst.enable",    b1.enable,    3'b111);
        check("rst.m0_enable", b0.enable,    3'b111);

        // Streaming with the consumer always ready
        run_stream("stream");

        // Back-pressure: fill with consumer stalled
        for (int c = 0; c < 4; c++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            #1;
            check("bp.in_ready", b1.in_ready,  bp_ir[c]);
            check("bp.occ",      b1.occupancy, bp_oc[c]);
            tick;
        end
        #1;
        check("bp_full.enable",    b1.enable,    3'b000);
        check("bp_full.in_ready",  b1.in_ready,  0);
        check("bp_full.occ",       b1.occupancy, 3);
        check("bp_full.m0_enable", b0.enable,    3'b000);
        out_ready = 1'b1;
        #1;
        check("bp_release.in_ready",  b1.in_ready, 1);
        check("bp_release.enable",    b1.enable,   3'b111);
        check("bp_release.m0_enable", b0.enable,   3'b111);
        tick;
        #1;
        check("bp_shift.occ",    b1.occupancy, 3);
        check("bp_shift.enable", b1.enable,    3'b111);
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        #1;
        check("bp_drain.occ",    b1.occupancy, 0);
        check("bp_drain.m0_occ", b0.occupancy, 0);

        // Bubble handling: A, idle, B with consumer stalled
        for (int t = 0; t < 6; t++) begin
            in_valid  = iv[t];
            out_ready = 1'b0;
            #1;
            check("bub.m1_in_ready", b1.in_ready,  1);
            check("bub.m0_in_ready", b0.in_ready,  m0_ir[t]);
            check("bub.m1_occ",      b1.occupancy, bo_oc[t]);
            check("bub.m0_occ",      b0.occupancy, bo_oc[t]);
            if (t == 4) begin
                check("bub.m1_enable", b1.enable, 3'b001);
                check("bub.m0_enable", b0.enable, 3'b000);
            end
            tick;
        end
        for (int t = 0; t < 4; t++) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            check("bub_drain.m1_out_valid", b1.out_valid, m1_ov[t]);
            check("bub_drain.m0_out_valid", b0.out_valid, m0_ov[t]);
            tick;
        end

        // Flush while full, with producer and consumer both active
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        tick;
        tick;
        flush = 1'b1;
        #1;
        check("flush.occ",         b1.occupancy, 3);
        check("flush.out_valid",   b1.out_valid, 1);
        check("flush.enable",      b1.enable,    3'b000);
        check("flush.in_ready",    b1.in_ready,  0);
        check("flush.m0_enable",   b0.enable,    3'b000);
        check("flush.m0_in_ready", b0.in_ready,  0);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_after.occ",       b1.occupancy, 0);
        check("flush_after.out_valid", b1.out_valid, 0);
        check("flush_after.m0_occ",    b0.occupancy, 0);
        tick;
        #1;
        check("flush_after2.occ", b1.occupancy, 0);

        // Asynchronous reset mid-stream with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        #1;
        check("arst_pre.occ",          b1.occupancy, 2);
        check("arst_pre.out_valid",    b1.out_valid, 1);
        check("arst_pre.m0_occ",       b0.occupancy, 2);
        check("arst_pre.m0_out_valid", b0.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", b1.out_valid, 0);
        check("arst.busy",      b1.busy,      0);
        check("arst.occ",       b1.occupancy, 0);
        check("arst.in_ready",  b1.in_ready,  1);
        check("arst.enable",    b1.enable,    3'b111);
        check("arst.m0_occ",    b0.occupancy, 0);
        tick;
        tick;
        rst_n = 1'b1;
        run_stream("restream");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pl_reg_flow_ctrl.md
Name: pl_reg_flow_ctrl

Overview:
- Valid/ready flow controller that drives the per-rank `enable` bus of a multi-stage pipeline register, such as a pipelined multiplier wrapped in DW_pl_reg.
- Sits alongside the data pipe and is its direct upstream control source: it tracks which ranks hold valid data, accepts items from the producer, presents them to the consumer, and applies back-pressure.
- The data path is not inside this block. The consumer samples the pipe's data_out when out_valid && out_ready.

Parameters:
stages, 4, pipeline stage count (2..32); R = stages-1 register ranks; enable width = R
stall_mode, 1, 0 = global stall (all ranks enabled together); 1 = bubble-collapsing (per-rank enables)
cnt_width, 3, occupancy width; must satisfy 2^cnt_width > R

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  producer has an item this cycle
in_ready  out  1  controller accepts the item this cycle
out_valid  out  1  last rank holds a valid item
out_ready  in  1  consumer accepts the item this cycle
flush  in  1  synchronous discard of all in-flight items
enable  out  R  load enable per rank; bit 0 = rank nearest input, bit R-1 = output rank
occupancy  out  cnt_width  number of valid ranks
busy  out  1  any rank valid

Behaviour:
- State: valid vector v[R-1:0], one bit per rank. No other state.
- Outputs:
  - out_valid = v[R-1]
  - occupancy = popcount(v)
  - busy = |v
  - enable and in_ready are combinational from v, out_ready and flush.
- Reset:
  - rst_n low clears v immediately, without a clock.
  - out_valid=0, occupancy=0, busy=0.
  - enable = all ones and in_ready = 1 (empty pipe), unless flush=1.
  - No transfer takes effect while rst_n is low.
- stall_mode=1 (bubble-collapsing):
  - en[R-1] = !v[R-1] | out_ready
  - en[i] = !v[i] | en[i+1], for i < R-1
- stall_mode=0 (global): every en[i] = !v[R-1] | out_ready.
- in_ready = en[0] in both modes.
- Update at each rising edge, when flush=0:
  - if en[i]: v[i] <= (i==0 ? in_valid : v[i-1]); otherwise v[i] holds.
  - A transfer in occurs on in_valid && in_ready; a transfer out occurs on out_valid && out_ready.
- Latency: an item accepted in cycle t is presented (out_valid=1) in cycle t+R when unstalled. Throughput is 1 item/cycle.
- An enable asserted for a bubble loads don't-care data. Its validity is tracked by v only.
- Flush:
  - Forces enable=0 and in_ready=0 in the same cycle.
  - out_valid still reflects v, but a consumer transfer in a flush cycle is dropped by definition.
  - Clears v at the next edge.
  - Flush overrides in_valid and out_ready.
- Simultaneous in+out transfers on a full pipe in mode 1: occupancy stays R and every rank shifts.
- Full pipe with out_ready=0: enable=0 and in_ready=0 in both modes.
- Mode 0 stalls on out_valid && !out_ready even when upstream ranks hold bubbles; bubbles are preserved, never collapsed.
- Combinational paths:
  - out_ready -> in_ready and out_ready -> enable are permitted, with a depth of R OR-levels.
  - No path exists from in_valid to in_ready.
- Parameter legality: stages < 2 or 2^cnt_width <= R is an elaboration error via a generate-time check.

Test Plan:
1. Reset (stages=4, mode 1). Hold rst_n=0, then release → out_valid=0, occupancy=0, busy=0, in_ready=1, enable=3'b111.
2. Stream, out_ready=1. in_valid=1 for 5 cycles starting t0 →
   - out_valid first high at t0+3, for 5 consecutive cycles;
   - occupancy reaches 3, holds at 3, then drains 3→2→1→0;
   - the 5 output transfers occur in order.
3. Back-pressure (mode 1). out_ready=0, in_valid=1 continuous → 3 accepts, then in_ready=0 and enable=000 with occupancy=3. Raising out_ready → in_ready=1 and enable=111 in the same cycle.
4. Bubble handling. Item A at t0, idle, item B at t2, out_ready=0 throughout →
   - mode 1: B collapses behind A, occupancy=2, v=3'b110, in_ready=1;
   - mode 0: in_ready=0 from t0+3, and the bubble between A and B persists.
5. Flush while full, with in_valid=1 and out_ready=1 in the flush cycle → enable=000 and in_ready=0 during the flush cycle; next cycle occupancy=0 and out_valid=0; no item accepted.
6. Asynchronous reset mid-stream. Drive rst_n low between clock edges with occupancy=2 → out_valid, busy and occupancy go to 0 immediately, before the next edge. After release, a new stream behaves as in scenario 2.
